// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and constants for the UART request arbiter
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] TIMEOUT_FILL  = 8'hFF;
  localparam logic [BYTE_W-1:0] NO_REPLY_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_TX_SETTLE = 3'd2,
    ST_WAIT_RX   = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_req_arbiter_rr_arbiter.sv
// rtl/uart_req_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest requester to ptr wins last.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IDX_W'(cand);
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_req_arbiter.sv
// rtl/uart_req_arbiter.sv - round-robin sharing of one UART TX/RX byte pair among NUM_REQ clients
// Optional reply timeout enabled by UART_ARB_TIMEOUT_EN.
module uart_req_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] in_req_data,
  input  logic [NUM_REQ-1:0]        in_req_expect_rx,
  output logic [NUM_REQ-1:0]        out_req_ack,
  output logic [NUM_REQ-1:0]        out_resp_valid,
  output logic [BYTE_W-1:0]         out_resp_data,
  output logic                      out_resp_timeout,
  output logic                      out_stray_rx,
  output logic [BYTE_W-1:0]         out_tx_data,
  output logic                      out_wr_strobe,
  input  logic                      in_tx_busy,
  input  logic [BYTE_W-1:0]         in_rx_data,
  input  logic                      in_rx_valid,
  output logic                      out_rd_strobe
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                exp_q, exp_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [BYTE_W-1:0]   resp_data_q, resp_data_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                stray_q, stray_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [BYTE_W-1:0]   grant_byte;
  logic                timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i       (in_req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  always_comb begin
    grant_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_byte = in_req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    win_onehot        = '0;
    win_onehot[win_q] = 1'b1;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             resp_to_q, resp_to_d;

  // A byte arriving on the final counted cycle still wins over the timeout.
  assign timeout_hit = (state_q == ST_WAIT_RX) && !in_rx_valid &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign to_cnt_d    = (state_q == ST_WAIT_RX) ? to_cnt_q + CNT_W'(1) : '0;
  assign resp_to_d   = (|resp_valid_d) ? timeout_hit : resp_to_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q  <= '0;
      resp_to_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      resp_to_q <= resp_to_d;
    end
  end

  assign out_resp_timeout = resp_to_q;
`else
  assign timeout_hit      = 1'b0;
  assign out_resp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      byte_q       <= '0;
      exp_q        <= 1'b0;
      ack_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      tx_data_q    <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      byte_q       <= byte_d;
      exp_q        <= exp_d;
      ack_q        <= ack_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      tx_data_q    <= tx_data_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      stray_q      <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (grant_any) state_d = ST_SEND;
      ST_SEND:      if (!in_tx_busy) state_d = ST_TX_SETTLE;
      ST_TX_SETTLE: state_d = exp_q ? ST_WAIT_RX : ST_DONE;
      ST_WAIT_RX:   if (in_rx_valid || timeout_hit) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    win_d        = win_q;
    byte_d       = byte_q;
    exp_d        = exp_q;
    ack_d        = '0;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    tx_data_d    = tx_data_q;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    stray_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          ack_d  = grant;
          win_d  = grant_idx;
          byte_d = grant_byte;
          exp_d  = in_req_expect_rx[grant_idx];
        end else if (in_rx_valid && !rd_q) begin
          // rd_q guard: the RX core only drops valid after it has seen our strobe.
          rd_d    = 1'b1;
          stray_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (!in_tx_busy) begin
          wr_d      = 1'b1;
          tx_data_d = byte_q;
        end
      end
      ST_TX_SETTLE: begin
        if (!exp_q) begin
          resp_valid_d = win_onehot;
          resp_data_d  = NO_REPLY_BYTE;
        end
      end
      ST_WAIT_RX: begin
        if (in_rx_valid) begin
          resp_valid_d = win_onehot;
          resp_data_d  = in_rx_data;
          rd_d         = 1'b1;
        end else if (timeout_hit) begin
          resp_valid_d = win_onehot;
          resp_data_d  = TIMEOUT_FILL;
        end
      end
      ST_DONE: begin
        ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
      default: begin
      end
    endcase
  end

  assign out_req_ack    = ack_q;
  assign out_resp_valid = resp_valid_q;
  assign out_resp_data  = resp_data_q;
  assign out_stray_rx   = stray_q;
  assign out_tx_data    = tx_data_q;
  assign out_wr_strobe  = wr_q;
  assign out_rd_strobe  = rd_q;

endmodule

// File: tb/tb_uart_req_arbiter.sv
// tb/tb_uart_req_arbiter.sv - self-checking bench for uart_req_arbiter
module tb_uart_req_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_exp;
  logic           tx_busy;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [N-1:0]   ack;
  logic [N-1:0]   resp_valid;
  logic [7:0]     resp_data;
  logic           resp_to;
  logic           stray;
  logic [7:0]     tx_data;
  logic           wr;
  logic           rd;

  uart_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .in_req_valid     (req_valid),
    .in_req_data      (req_data),
    .in_req_expect_rx (req_exp),
    .out_req_ack      (ack),
    .out_resp_valid   (resp_valid),
    .out_resp_data    (resp_data),
    .out_resp_timeout (resp_to),
    .out_stray_rx     (stray),
    .out_tx_data      (tx_data),
    .out_wr_strobe    (wr),
    .in_tx_busy       (tx_busy),
    .in_rx_data       (rx_data),
    .in_rx_valid      (rx_valid),
    .out_rd_strobe    (rd)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; logic [7:0] data; logic exp;} txn_t;
  typedef struct {int idx; logic [7:0] wr; logic [7:0] resp; logic to;} exp_t;
  typedef struct {
    logic [N-1:0] mask; logic [N*8-1:0] data; logic [N-1:0] exp;
    int busy; int rx_dly; int first_idx; logic [7:0] first_wr; logic [7:0] first_resp;
  } vec_t;

  txn_t       pend[$];
  exp_t       exq[$];
  int         ack_log[$];
  int         ack_cyc[$];
  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  logic [7:0] resp_log[$];
  int         resp_cyc[$];

  int checks = 0, errors = 0, cyc = 0;
  int rd_cnt = 0, stray_cnt = 0, resp_cnt = 0;
  int m_ptr = 0, busy_left = 0, rx_dly_cfg = 0, rx_delay = -1;
  bit rand_busy = 0, no_reply = 0;
  logic cur_exp = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  vec_t vt[6];
  int   order_ref[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : 99;
    return r;
  endfunction

  function automatic void drive_reqs();
    bit found;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      found = 0;
      foreach (pend[j]) begin
        if (!found && pend[j].idx == i) begin
          found = 1;
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = pend[j].data;
          req_exp[i] = pend[j].exp;
        end
      end
    end
  endfunction

  // Reference: all loaded transactions wait together; serve nearest requester at or after ptr.
  function automatic void model_plan();
    txn_t work[$];
    int w, c, pos;
    work = pend;
    while (work.size() > 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0) foreach (work[j]) if (work[j].idx == c) w = c;
      end
      pos = -1;
      foreach (work[j]) if (pos < 0 && work[j].idx == w) pos = j;
      exq.push_back('{idx: w, wr: work[pos].data,
                      resp: work[pos].exp ? (work[pos].data ^ 8'hF0) : 8'h00, to: 1'b0});
      work.delete(pos);
      m_ptr = (w + 1) % N;
    end
  endfunction

  function automatic void plan_manual(input int idx, input logic [7:0] d,
                                      input logic [7:0] r, input logic t);
    exq.push_back('{idx: idx, wr: d, resp: r, to: t});
    m_ptr = (idx + 1) % N;
  endfunction

  function automatic void clear_logs();
    ack_log.delete(); ack_cyc.delete(); wr_log.delete();
    wr_cyc.delete(); resp_log.delete(); resp_cyc.delete();
  endfunction

  task automatic step();
    int a, pos;
    @(negedge clk);
    cyc++;
    if (ack != '0) begin
      a = onehot_idx(ack);
      ack_log.push_back(a);
      ack_cyc.push_back(cyc);
      chk("ack_expected", exq.size() > 0, 1);
      if (exq.size() > 0) chk("ack_idx", a, exq[0].idx);
      pos = -1;
      foreach (pend[j]) if (pos < 0 && pend[j].idx == a) pos = j;
      if (pos >= 0) begin
        cur_exp = pend[pos].exp;
        pend.delete(pos);
      end else cur_exp = 1'b0;
    end
    if (wr) begin
      wr_log.push_back(tx_data);
      wr_cyc.push_back(cyc);
      chk("wr_while_busy", tx_busy, 0);
      chk("wr_expected", exq.size() > 0, 1);
      if (exq.size() > 0) chk("wr_byte", tx_data, exq[0].wr);
      if (cur_exp && !no_reply) begin
        rx_delay = (rx_dly_cfg < 0) ? $urandom_range(0, 6) : rx_dly_cfg;
        rx_byte  = tx_data ^ 8'hF0;
      end
    end
    if (rd) begin
      rd_cnt++;
      chk("rd_with_rx_valid", rx_valid, 1);
      rx_valid = 1'b0;
    end
    if (stray) stray_cnt++;
    if (resp_valid != '0) begin
      resp_cnt++;
      resp_log.push_back(resp_data);
      resp_cyc.push_back(cyc);
      chk("resp_expected", exq.size() > 0, 1);
      if (exq.size() > 0) begin
        chk("resp_idx", onehot_idx(resp_valid), exq[0].idx);
        chk("resp_data", resp_data, exq[0].resp);
        chk("resp_timeout", resp_to, exq[0].to);
        void'(exq.pop_front());
      end
    end
    drive_reqs();
    if (rx_delay == 0) begin
      rx_valid = 1'b1;
      rx_data  = rx_byte;
      rx_delay = -1;
    end else if (rx_delay > 0) rx_delay--;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else tx_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  task automatic run_done(input int bound);
    int n;
    n = 0;
    while ((pend.size() > 0 || exq.size() > 0) && n < bound) begin
      step();
      n++;
    end
    chk("run_complete", pend.size() + exq.size(), 0);
    step();
    step();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_resp_to"}, resp_to, 0);
    chk({tag, "_stray"}, stray, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_rd"}, rd, 0);
  endtask

  initial begin
    int rd0, st0, rs0, n, a;

    vt[0] = '{mask: 3'b011, data: 24'h004241, exp: 3'b000, busy: 0,  rx_dly: 0,  first_idx: 0, first_wr: 8'h41, first_resp: 8'h00};
    vt[1] = '{mask: 3'b010, data: 24'h005500, exp: 3'b010, busy: 10, rx_dly: 20, first_idx: 1, first_wr: 8'h55, first_resp: 8'hA5};
    vt[2] = '{mask: 3'b101, data: 24'h120010, exp: 3'b000, busy: 0,  rx_dly: 0,  first_idx: 2, first_wr: 8'h12, first_resp: 8'h00};
    vt[3] = '{mask: 3'b111, data: 24'h222120, exp: 3'b100, busy: 0,  rx_dly: 1,  first_idx: 1, first_wr: 8'h21, first_resp: 8'h00};
    vt[4] = '{mask: 3'b001, data: 24'h0000FF, exp: 3'b001, busy: 2,  rx_dly: 3,  first_idx: 0, first_wr: 8'hFF, first_resp: 8'h0F};
    vt[5] = '{mask: 3'b100, data: 24'h000000, exp: 3'b100, busy: 0,  rx_dly: 0,  first_idx: 2, first_wr: 8'h00, first_resp: 8'hF0};
    order_ref = '{0, 1, 0, 1, 0, 1};

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_exp = '0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    step(); step();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    for (int r = 0; r < 6; r++) begin
      clear_logs();
      rd0 = rd_cnt;
      for (int i = 0; i < N; i++)
        if (vt[r].mask[i]) pend.push_back('{idx: i, data: vt[r].data[i*8 +: 8], exp: vt[r].exp[i]});
      model_plan();
      rx_dly_cfg = vt[r].rx_dly;
      if (vt[r].busy > 0) begin
        tx_busy   = 1'b1;
        busy_left = vt[r].busy - 1;
      end
      drive_reqs();
      run_done(500);
      chk($sformatf("row%0d_first_ack", r), ack_log.size() > 0 ? ack_log[0] : -1, vt[r].first_idx);
      chk($sformatf("row%0d_first_wr", r), wr_log.size() > 0 ? wr_log[0] : 8'hxx, vt[r].first_wr);
      chk($sformatf("row%0d_first_resp", r), resp_log.size() > 0 ? resp_log[0] : 8'hxx, vt[r].first_resp);
      chk($sformatf("row%0d_rd_count", r), rd_cnt - rd0, $countones(vt[r].mask & vt[r].exp));
    end

    clear_logs();
    for (int k = 0; k < 6; k++) pend.push_back('{idx: k % 2, data: 8'h60 + 8'(k), exp: 1'b0});
    model_plan();
    drive_reqs();
    run_done(500);
    for (int k = 0; k < 6; k++)
      chk($sformatf("fair_order_%0d", k), ack_log.size() > k ? ack_log[k] : -1, order_ref[k]);

    clear_logs();
    for (int k = 0; k < 3; k++) pend.push_back('{idx: 2, data: 8'h70 + 8'(k), exp: 1'b0});
    model_plan();
    drive_reqs();
    run_done(500);
    for (int k = 1; k < 3; k++)
      chk("lone_ack_spacing", ack_cyc.size() > k ? ack_cyc[k] - ack_cyc[k-1] : -1, 4);

    rd0 = rd_cnt; st0 = stray_cnt; rs0 = resp_cnt;
    rx_valid = 1'b1; rx_data = 8'h33;
    for (int k = 0; k < 4; k++) step();
    chk("stray_rd_count", rd_cnt - rd0, 1);
    chk("stray_pulse_count", stray_cnt - st0, 1);
    chk("stray_no_resp", resp_cnt - rs0, 0);
    chk("stray_drained", rx_valid, 0);

    clear_logs();
    rd0 = rd_cnt; st0 = stray_cnt;
    no_reply = 1;
    rx_valid = 1'b1; rx_data = 8'h77;
    pend.push_back('{idx: 1, data: 8'h88, exp: 1'b1});
    plan_manual(1, 8'h88, 8'h77, 1'b0);
    drive_reqs();
    run_done(500);
    chk("collide_no_stray", stray_cnt - st0, 0);
    chk("collide_rd_count", rd_cnt - rd0, 1);
    no_reply = 0;

`ifdef UART_ARB_TIMEOUT_EN
    clear_logs();
    no_reply = 1;
    pend.push_back('{idx: 0, data: 8'h31, exp: 1'b1});
    plan_manual(0, 8'h31, 8'hFF, 1'b1);
    drive_reqs();
    run_done(500);
    chk("timeout_latency", (resp_cyc.size() > 0 && wr_cyc.size() > 0) ? resp_cyc[0] - wr_cyc[0] : -1, TO + 1);
    no_reply = 0;

    clear_logs();
    rx_dly_cfg = TO;
    pend.push_back('{idx: 0, data: 8'h32, exp: 1'b1});
    plan_manual(0, 8'h32, 8'hC2, 1'b0);
    drive_reqs();
    run_done(500);
    chk("last_cycle_rx_latency", (resp_cyc.size() > 0 && wr_cyc.size() > 0) ? resp_cyc[0] - wr_cyc[0] : -1, TO + 1);
`endif

    clear_logs();
    no_reply = 1;
    pend.push_back('{idx: 0, data: 8'h44, exp: 1'b1});
    plan_manual(0, 8'h44, 8'h00, 1'b0);
    drive_reqs();
    n = 0;
    while (wr_log.size() == 0 && n < 50) begin
      step();
      n++;
    end
    chk("reset_test_wr_seen", wr_log.size(), 1);
    step(); step(); step();
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    rs0 = resp_cnt;
    pend.delete(); exq.delete();
    rx_delay = -1; m_ptr = 0; cur_exp = 1'b0;
    drive_reqs();
    step(); step();
    chk("midreset_no_resp", resp_cnt - rs0, 0);
    rst_n = 1'b1;
    no_reply = 0;
    clear_logs();
    pend.push_back('{idx: 1, data: 8'h66, exp: 1'b0});
    model_plan();
    drive_reqs();
    run_done(500);
    chk("post_reset_ack", ack_log.size() > 0 ? ack_log[0] : -1, 1);
    chk("post_reset_resp", resp_log.size(), 1);

    rand_busy = 1;
    rx_dly_cfg = -1;
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        a = $urandom_range(0, N - 1);
        pend.push_back('{idx: a, data: 8'($urandom), exp: 1'($urandom_range(0, 1))});
      end
      model_plan();
      drive_reqs();
      run_done(2000);
    end
    rand_busy = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_req_arbiter.md
Name: uart_req_arbiter

Overview:
- Shares one UART TX/RX byte pair between NUM_REQ requesters. Each requester issues one transaction: send one byte, then optionally wait for one reply byte.
- Round-robin arbitration. Only one transaction is in flight at a time.
- Sits between user-side peripheral logic and the UART TX/RX cores. It replaces per-client send/receive sequencers.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1000000, cycles to wait for the reply byte. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_req_valid  in  NUM_REQ  per-requester request. Level signal, held until its ack.
- in_req_data  in  NUM_REQ*8  per-requester TX byte; requester i uses bits [8i+7:8i].
- in_req_expect_rx  in  NUM_REQ  1 = transaction waits for a reply byte.
- out_req_ack  out  NUM_REQ  one-cycle pulse when the request is latched.
- out_resp_valid  out  NUM_REQ  one-cycle pulse when the transaction completes.
- out_resp_data  out  8  reply byte. Valid with any out_resp_valid bit.
- out_resp_timeout  out  1  qualifies out_resp_valid: reply timed out.
- out_stray_rx  out  1  one-cycle pulse when an unsolicited RX byte is drained.
- out_tx_data  out  8  byte to the UART TX core.
- out_wr_strobe  out  1  one-cycle TX write strobe.
- in_tx_busy  in  1  TX core busy.
- in_rx_data  in  8  byte from the UART RX core.
- in_rx_valid  in  1  RX byte available.
- out_rd_strobe  out  1  one-cycle RX consume strobe.

Behaviour:
- Reset (async, reset=0):
  - State IDLE; round-robin pointer = 0.
  - All outputs 0, including out_tx_data and out_resp_data. Timeout counter = 0.
  - Reset mid-transaction abandons it; no resp pulse is issued.
- Registered outputs. Every strobe or pulse is exactly one cycle wide.
- IDLE:
  - If any in_req_valid is set, pick the winner. Search starts at index ptr, ascending, wrapping at NUM_REQ-1 to 0.
  - Latch the winner's index, data byte and expect_rx flag. Pulse out_req_ack[winner]. Go to SEND.
  - If in_rx_valid and no request is pending: pulse out_rd_strobe and out_stray_rx, discard the byte.
  - If a request and in_rx_valid arrive in the same cycle: the request wins, and the RX byte stays pending for WAIT_RX.
- SEND:
  - While in_tx_busy=1, hold.
  - When in_tx_busy=0: drive out_tx_data = latched byte and pulse out_wr_strobe.
  - Next state: TX_SETTLE.
- TX_SETTLE:
  - Lasts one cycle to cover the TX core's busy latency.
  - Next state: WAIT_RX if expect_rx=1, else DONE with out_resp_data = 0x00.
- WAIT_RX:
  - On in_rx_valid: capture in_rx_data into out_resp_data, pulse out_rd_strobe, go to DONE.
- DONE:
  - Pulse out_resp_valid[winner].
  - Set ptr = (winner+1) mod NUM_REQ; go to IDLE.
  - out_resp_data and out_resp_timeout hold until the next DONE.
  - Requests are not sampled in DONE. A request present in DONE is served from IDLE the following cycle, i.e. at least one idle cycle between transactions.
- Fairness:
  - A requester that holds in_req_valid continuously is served at most once per NUM_REQ transactions while others are waiting.
  - Lone requester back-to-back: one ack every transaction, with 4 cycles minimum between acks when TX is not busy and no RX is expected.
- Width rules:
  - Winner index width is clog2(NUM_REQ), minimum 1.
  - Pointer wrap-around is explicit; no reliance on power-of-two NUM_REQ.
- in_req_valid is ignored for the current winner until it is back in IDLE. Dropping a request before its ack withdraws it silently.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RX and increments each cycle there.
  - When the count reaches TIMEOUT_CYCLES-1 with no in_rx_valid: go to DONE with out_resp_data=0xFF and out_resp_timeout=1.
  - If in_rx_valid arrives on that final cycle, the byte wins and the timeout is not flagged.
  - A late byte arriving after the timeout is drained in IDLE as stray.
- Undefined:
  - No counter logic; WAIT_RX waits indefinitely.
  - out_resp_timeout is tied to 0. The port still exists.

Decomposition:
- Package uart_arb_pkg:
  - State encoding (IDLE, SEND, TX_SETTLE, WAIT_RX, DONE), using explicit values with an illegal-state default that returns to IDLE.
  - Byte width constant 8; timeout fill byte 0xFF.
- Sub-module rr_arbiter (NUM_REQ parameter): combinational round-robin pick from request vector and ptr. Outputs a one-hot grant and a grant index.

Test Plan:
- NUM_REQ=2, both request in the same cycle; req0=0x41 no RX, req1=0x42 no RX, in_tx_busy=0 -> ack[0] first, then 0x41 written; later ack[1] and 0x42 written; resp_valid[0] then resp_valid[1], resp_data=0x00.
- req1=0x55 expect_rx=1; in_tx_busy held 1 for 10 cycles -> no wr_strobe until busy drops; rx byte 0xA5 given 20 cycles later -> one rd_strobe, resp_valid[1], resp_data=0xA5.
- Both requests held continuously for 6 transactions -> ack order is 0,1,0,1,0,1.
- in_rx_valid with byte 0x33 while IDLE and no requests -> one rd_strobe, one out_stray_rx, no resp_valid.
- Built with UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, expect_rx=1, no RX -> resp_valid after 16 WAIT_RX cycles with resp_data=0xFF and out_resp_timeout=1. Repeat with RX on the 16th cycle -> data captured, timeout=0.
- Assert reset during WAIT_RX -> outputs 0 immediately, no resp_valid; after release, a new request completes normally.
